reg_bank_reader: RTL and testbench
==================================

// Module: reg_bank_reader
// PURPOSE
//  General-purpose register bank of the multi-cycle MIPS datapath: the consumer end of the
//  register write-data selection path. It stores 32 x 32-bit registers, accepts one write per
//  cycle from the write-data mux, and returns two registered read operands (A/B) to the ALU
//  path. A debug dump engine streams the whole bank out, one word per cycle, for testbenches.
// PARAMETERS
//  SP_INDEX     29     register index preloaded at reset (stack pointer)
//  SP_RESET     227    reset value of register SP_INDEX (32'h000000E3)
// PORTS
//  clock        in   1   clock; all state updates on rising edge
//  reset_n      in   1   synchronous, active-low reset
//  RegWrite     in   1   write enable
//  WriteReg     in   5   write register index
//  WriteDataFio in   32  write data (from write-data mux)
//  ReadReg1     in   5   read index, port A
//  ReadReg2     in   5   read index, port B
//  ReadEn       in   1   capture A/B this cycle
//  ReadData1    out  32  registered operand A
//  ReadData2    out  32  registered operand B
//  DumpReq      in   1   start full-bank dump (pulse)
//  DumpBusy     out  1   dump in progress
//  DumpValid    out  1   DumpIdx/DumpData valid this cycle
//  DumpIdx      out  5   register index being dumped
//  DumpData     out  32  register contents being dumped
// BEHAVIOUR
//  Reset (reset_n=0 at edge): all registers 0 except reg[SP_INDEX]=SP_RESET; ReadData1/2=0;
//   DumpBusy=0, DumpValid=0, DumpIdx=0, DumpData=0; dump FSM -> IDLE. Mid-dump reset aborts dump.
//  Write: if RegWrite && WriteReg!=0, reg[WriteReg] <= WriteDataFio at edge. Writes to reg 0
//   are discarded; reg 0 always reads 0.
//  Read: if ReadEn, ReadData1 <= value(ReadReg1), ReadData2 <= value(ReadReg2) at edge;
//   latency 1 cycle; if !ReadEn both outputs hold their previous value.
//  Bypass: value(r) = WriteDataFio when RegWrite && WriteReg==r && r!=0 in the same cycle,
//   else reg[r]; value(0)=0 always. Both ports may bypass simultaneously.
//  Dump FSM states IDLE, RUN:
//   IDLE: DumpReq=1 -> RUN, idx<=0. Otherwise stay. DumpValid=0.
//   RUN: each cycle DumpValid=1, DumpIdx=idx, DumpData=value(idx) (bypass applies), registered
//    (outputs appear the cycle after idx is selected); idx increments; after idx 31 emitted ->
//    IDLE next cycle. Exactly 32 valid beats, indices 0..31 ascending, no gaps.
//   DumpBusy=1 from cycle after DumpReq until cycle after the beat with DumpIdx=31.
//   DumpReq while in RUN is ignored (no restart). Writes/reads proceed normally during a dump.
//  Index wrap: idx is 5 bits; no wrap past 31 — FSM exits at 31.
// TESTING
//  1. Reset: reset_n=0 one edge -> dump shows reg29=227, all others 0; ReadData1/2=0.
//  2. Write/read: write reg5=32'hDEADBEEF, next cycle ReadReg1=5, ReadEn=1 -> ReadData1=DEADBEEF after 1 edge.
//  3. Reg0: RegWrite, WriteReg=0, data=32'h12345678 -> ReadReg1=0 yields 0; dump beat 0 = 0.
//  4. Bypass: same cycle RegWrite reg7=32'hA5A5A5A5, ReadReg1=ReadReg2=7, ReadEn=1 -> both = A5A5A5A5.
//  5. Dump: after writing reg[i]=i*4, DumpReq pulse -> 32 consecutive beats, DumpIdx 0..31, data i*4
//     (reg29 overwritten), DumpReq mid-dump ignored.
//  6. Reset mid-dump: reset_n=0 at beat 10 -> DumpBusy=0, DumpValid=0 next cycle, bank back to reset values.

Source files
------------

// File: rtl/reg_bank_reader.sv
// 32 x 32-bit MIPS register bank with two registered read ports and write bypass.
// A dump engine streams every register out in ascending order, one word per cycle.
module reg_bank_reader #(
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_RESET = 32'h000000E3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteDataFio,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic        ReadEn,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    input  logic        DumpReq,
    output logic        DumpBusy,
    output logic        DumpValid,
    output logic [4:0]  DumpIdx,
    output logic [31:0] DumpData
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dump_state_t;

    logic [31:0] r_regs [32];
    dump_state_t r_state;
    dump_state_t w_next_state;
    logic [4:0]  r_idx;
    logic        w_dump_start;
    logic        w_write_en;
    logic [31:0] w_rd1_val;
    logic [31:0] w_rd2_val;
    logic [31:0] w_dump_val;

    assign w_write_en = RegWrite && (WriteReg != 5'd0);

    // A same-cycle write to the addressed register wins over the stored value; reg 0 is hardwired.
    function automatic logic [31:0] read_value(input logic [4:0] idx);
        if (idx == 5'd0)
            return 32'd0;
        if (w_write_en && (WriteReg == idx))
            return WriteDataFio;
        return r_regs[idx];
    endfunction

    assign w_rd1_val  = read_value(ReadReg1);
    assign w_rd2_val  = read_value(ReadReg2);
    assign w_dump_val = read_value(r_idx);

    always_comb begin
        w_next_state = r_state;
        w_dump_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (DumpReq) begin
                    w_next_state = RUN;
                    w_dump_start = 1'b1;
                end
            end
            RUN: begin
                if (r_idx == 5'd31)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Busy covers the RUN cycles plus the cycle presenting the final beat.
    assign DumpBusy = (r_state == RUN) || DumpValid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
            ReadData1 <= 32'd0;
            ReadData2 <= 32'd0;
            r_state   <= IDLE;
            r_idx     <= 5'd0;
            DumpValid <= 1'b0;
            DumpIdx   <= 5'd0;
            DumpData  <= 32'd0;
        end else begin
            if (w_write_en)
                r_regs[WriteReg] <= WriteDataFio;

            if (ReadEn) begin
                ReadData1 <= w_rd1_val;
                ReadData2 <= w_rd2_val;
            end

            r_state <= w_next_state;
            if (w_dump_start)
                r_idx <= 5'd0;
            else if (r_state == RUN)
                r_idx <= r_idx + 5'd1;

            DumpValid <= (r_state == RUN);
            if (r_state == RUN) begin
                DumpIdx  <= r_idx;
                DumpData <= w_dump_val;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Randomized bench for reg_bank_reader against an array-and-queue reference model.
// Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
module tb_reg_bank_reader;

    logic        clock;
    logic        reset_n;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteDataFio;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        ReadEn;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        DumpReq;
    logic        DumpBusy;
    logic        DumpValid;
    logic [4:0]  DumpIdx;
    logic [31:0] DumpData;

    reg_bank_reader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .RegWrite     (RegWrite),
        .WriteReg     (WriteReg),
        .WriteDataFio (WriteDataFio),
        .ReadReg1     (ReadReg1),
        .ReadReg2     (ReadReg2),
        .ReadEn       (ReadEn),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .DumpReq      (DumpReq),
        .DumpBusy     (DumpBusy),
        .DumpValid    (DumpValid),
        .DumpIdx      (DumpIdx),
        .DumpData     (DumpData)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model: bank contents, expected operands, and expected dump beats
    logic [31:0] m_bank [32];
    logic [31:0] m_rd1;
    logic [31:0] m_rd2;
    bit          m_run;
    int          m_idx;
    logic [36:0] exp_q [$];

    int n_tests;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_val(input logic [4:0] r, input bit we,
                                             input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return m_bank[r];
    endfunction

    // one clock cycle: drive, predict, advance, compare
    task automatic cyc(input bit rst_n, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit re, input bit dreq);
        bit          pushed;
        logic [36:0] e;
        @(negedge clock);
        reset_n = rst_n; RegWrite = we; WriteReg = wr; WriteDataFio = wd;
        ReadReg1 = r1; ReadReg2 = r2; ReadEn = re; DumpReq = dreq;
        pushed = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_bank[i] = (i == 29) ? 32'd227 : 32'd0;
            m_rd1 = 32'd0; m_rd2 = 32'd0; m_run = 1'b0; m_idx = 0;
            exp_q.delete();
        end else begin
            if (re) begin
                m_rd1 = model_val(r1, we, wr, wd);
                m_rd2 = model_val(r2, we, wr, wd);
            end
            if (m_run) begin
                exp_q.push_back({m_idx[4:0], model_val(m_idx[4:0], we, wr, wd)});
                pushed = 1'b1;
                if (m_idx == 31) m_run = 1'b0;
                else m_idx++;
            end else if (dreq) begin
                m_run = 1'b1;
                m_idx = 0;
            end
            if (we && wr != 5'd0) m_bank[wr] = wd;
        end
        @(posedge clock);
        #1;
        check("rd1", ReadData1, m_rd1);
        check("rd2", ReadData2, m_rd2);
        check("dump_valid", {31'd0, DumpValid}, {31'd0, pushed});
        check("dump_busy", {31'd0, DumpBusy}, {31'd0, (m_run || pushed)});
        if (pushed) begin
            e = exp_q.pop_front();
            check("dump_idx", {27'd0, DumpIdx}, {27'd0, e[36:32]});
            check("dump_data", DumpData, e[31:0]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_run   = 1'b0;
        m_idx   = 0;
        m_rd1   = 32'd0;
        m_rd2   = 32'd0;
        reset_n = 1'b0; RegWrite = 1'b0; WriteReg = '0; WriteDataFio = '0;
        ReadReg1 = '0; ReadReg2 = '0; ReadEn = 1'b0; DumpReq = 1'b0;

        // reset, then dump the reset image
        cyc(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd29, 5'd0, 1, 1);
        idle(34);

        // write then read back
        cyc(1, 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd5, 5'd29, 1, 0);
        // write to reg 0 is discarded
        cyc(1, 1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd5, 1, 0);
        // both ports bypass the same-cycle write
        cyc(1, 1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd1, 5'd2, 0, 0);

        // reg[i] = i*4, then a full dump with a request mid-dump that must be ignored
        for (int i = 0; i < 32; i++) cyc(1, 1, i[4:0], i * 4, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 1);
        for (int i = 0; i < 36; i++) cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, (i == 12));

        // reset mid-dump, then verify the bank is back to reset values
        cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 1);
        idle(10);
        cyc(0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 0);
        cyc(1, 0, 5'd0, 32'd0, 5'd0, 5'd0, 0, 1);
        idle(34);

        // random traffic, including dumps overlapping writes and occasional resets
        for (int i = 0; i < 600; i++) begin
            logic [4:0]  wr;
            logic [4:0]  r1;
            logic [4:0]  r2;
            wr = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), wr, $urandom,
                r1, r2, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end
        idle(34);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
